// File: rtl/imem_loader.sv
// imem_loader: loads a framed 8-bit host byte stream into 24-bit instruction memory and holds proc in reset until the checksum verifies
module imem_loader #(
    parameter int mem_size = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  host_data,
    input  logic        host_valid,
    output logic        host_ready,
    output logic [23:0] iwaddr,
    output logic [23:0] iwdata,
    output logic        iwen,
    output logic        proc_rst,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {CNT_HI, CNT_LO, W0, W1, W2, CHK, DONE, ERR} state_t;
    localparam logic [16:0] max_cnt = 17'(mem_size);
    state_t      state;
    logic [15:0] cnt;
    logic [15:0] idx;
    logic [15:0] word;
    logic [7:0]  csum;
    logic        take;
    assign take = host_valid && host_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CNT_HI;
            cnt        <= '0;
            idx        <= '0;
            word       <= '0;
            csum       <= '0;
            iwaddr     <= '0;
            iwdata     <= '0;
            iwen       <= 1'b0;
            host_ready <= 1'b1;
            proc_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            iwen <= 1'b0;
            if (take) begin
                // the checksum byte itself is never folded into the running XOR
                if (state != CHK) csum <= csum ^ host_data;
                case (state)
                    CNT_HI: begin
                        cnt[15:8] <= host_data;
                        state     <= CNT_LO;
                    end
                    CNT_LO: begin
                        cnt[7:0] <= host_data;
                        if ({1'b0, cnt[15:8], host_data} > max_cnt) begin
                            state      <= ERR;
                            err        <= 1'b1;
                            host_ready <= 1'b0;
                        end else begin
                            state <= ({cnt[15:8], host_data} == 16'd0) ? CHK : W0;
                        end
                    end
                    W0: begin
                        word[15:8] <= host_data;
                        state      <= W1;
                    end
                    W1: begin
                        word[7:0] <= host_data;
                        state     <= W2;
                    end
                    W2: begin
                        iwdata <= {word, host_data};
                        iwaddr <= {8'h00, idx};
                        iwen   <= 1'b1;
                        idx    <= idx + 16'd1;
                        state  <= (idx == cnt - 16'd1) ? CHK : W0;
                    end
                    CHK: begin
                        state      <= (host_data == csum) ? DONE : ERR;
                        done       <= host_data == csum;
                        err        <= host_data != csum;
                        proc_rst   <= host_data != csum;
                        host_ready <= 1'b0;
                    end
                    default: state <= state;
                endcase
            end
        end
    end
endmodule
